// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: sequencer states, word size and next-pc select codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_e;

  // Redirect priority: jr over jump over taken branch over sequential.
  function automatic logic [1:0] npc_select(input logic jr, input logic jump,
                                            input logic branch_taken);
    if (jr)                return NPC_JR;
    else if (jump)         return NPC_JUMP;
    else if (branch_taken) return NPC_BRANCH;
    else                   return NPC_SEQ;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_mux.sv
// Combinational next-pc selector; shared with any later pipelined fetch stage.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pcplus4,
  input  logic [31:0] br_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic [1:0]  sel,
  output logic [31:0] next_pc
);

  // br_offset arrives already sign-extended and shifted; the add wraps mod 2^32.
  always_comb begin
    next_pc = pcplus4;
    case (npc_sel_e'(sel))
      NPC_JR:     next_pc = jr_target;
      NPC_JUMP:   next_pc = {pcplus4[31:28], jump_index, 2'b00};
      NPC_BRANCH: next_pc = pcplus4 + br_offset;
      default:    next_pc = pcplus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: fetch FSM, pc register, accepted-fetch counter and
// the sticky misaligned-jr error.
module pc_fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_rdy,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [31:0]      br_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pcplus4,
  output logic             imem_req,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign_err
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             req_q, req_d;

  logic [31:0] next_pc;
  logic        accept;
  logic        jr_misalign;

  assign pcplus4     = pc_q + 32'(WORD_BYTES);
  assign accept      = (state_q == FS_FETCH) && imem_rdy && !stall && !halt;
  assign jr_misalign = jr && (jr_target[1:0] != 2'b00);

  next_pc_mux u_next_pc_mux (
    .pcplus4    (pcplus4),
    .br_offset  (br_offset),
    .jump_index (jump_index),
    .jr_target  (jr_target),
    .sel        (npc_select(jr, jump, branch_taken)),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      FS_IDLE: state_d = FS_FETCH;
      FS_FETCH: begin
        if (halt) begin
          state_d = FS_HALTED;
        end else if (accept && jr_misalign) begin
          // The faulting jr is consumed without moving pc or counting a fetch.
          err_d   = 1'b1;
          state_d = FS_HALTED;
        end else if (accept) begin
          pc_d  = next_pc;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FS_HALTED: state_d = FS_HALTED;
      default:   state_d = FS_IDLE;
    endcase
    req_d = (state_d == FS_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_cnt    = cnt_q;
  assign misalign_err = err_q;
  assign imem_req     = req_q;
  assign fetch_valid  = accept && !jr_misalign;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench: stimulus pushes the expected (pc, count) of each accepted
// fetch; a negedge monitor pops and compares whenever fetch_valid pulses.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CNT_W    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             imem_rdy;
  logic             halt;
  logic             branch_taken;
  logic [31:0]      br_offset;
  logic             jump;
  logic [25:0]      jump_index;
  logic             jr;
  logic [31:0]      jr_target;
  logic [31:0]      pc;
  logic [31:0]      pcplus4;
  logic             imem_req;
  logic             fetch_valid;
  logic [CNT_W-1:0] fetch_cnt;
  logic             misalign_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
  } fetch_exp_t;

  fetch_exp_t exp_q[$];

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .imem_rdy     (imem_rdy),
    .halt         (halt),
    .branch_taken (branch_taken),
    .br_offset    (br_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .pc           (pc),
    .pcplus4      (pcplus4),
    .imem_req     (imem_req),
    .fetch_valid  (fetch_valid),
    .fetch_cnt    (fetch_cnt),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  initial assert (RESET_PC[1:0] == 2'b00) else $error("RESET_PC not word aligned");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] epc, input logic [31:0] ecnt);
    fetch_exp_t e;
    e.pc  = epc;
    e.cnt = ecnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fetch actual pc=%h cnt=%0d required=no fetch", pc, fetch_cnt);
      end else begin
        fetch_exp_t e;
        e = exp_q.pop_front();
        chk("fetch_pc", pc, e.pc);
        chk("fetch_cnt", fetch_cnt, e.cnt);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; imem_rdy = 1'b1; halt = 1'b0;
    branch_taken = 1'b0; br_offset = '0; jump = 1'b0; jump_index = '0;
    jr = 1'b0; jr_target = '0;

    // Reset held two cycles, then the single IDLE cycle.
    tick(); tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    reset = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    chk("idle_valid", {31'd0, fetch_valid}, 32'd0);
    tick();

    // Sequential fetches 0,4,8 then C held by stall.
    expect_fetch(32'h0, 32'd0); tick();
    expect_fetch(32'h4, 32'd1); tick();
    expect_fetch(32'h8, 32'd2); tick();
    stall = 1'b1;
    #1;
    chk("seq_pc", pc, 32'hC);
    chk("seq_cnt", fetch_cnt, 32'd3);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("stall_valid", {31'd0, fetch_valid}, 32'd0);
    stall = 1'b0;

    // Branches from 0x40: backward -16 -> 0x34, forward +0x100 -> 0x144.
    jr = 1'b1; jr_target = 32'h40; expect_fetch(32'hC, 32'd3); tick();
    jr = 1'b0; branch_taken = 1'b1; br_offset = 32'hFFFF_FFF0;
    expect_fetch(32'h40, 32'd4); tick();
    branch_taken = 1'b0; jr = 1'b1; jr_target = 32'h40;
    expect_fetch(32'h34, 32'd5); tick();
    jr = 1'b0; branch_taken = 1'b1; br_offset = 32'h100;
    expect_fetch(32'h40, 32'd6); tick();
    branch_taken = 1'b0;
    chk("br_fwd_pc", pc, 32'h144);

    // Jump keeps pcplus4[31:28]; jr beats jump in the same cycle.
    jr = 1'b1; jr_target = 32'h1000_0010; expect_fetch(32'h144, 32'd7); tick();
    jr = 1'b0; jump = 1'b1; jump_index = 26'h000_0040;
    expect_fetch(32'h1000_0010, 32'd8); tick();
    chk("jump_pc", pc, 32'h1000_0100);
    jr = 1'b1; jr_target = 32'h200;
    expect_fetch(32'h1000_0100, 32'd9); tick();
    jump = 1'b0; jr = 1'b0;
    chk("jr_prio_pc", pc, 32'h200);

    // Stall and memory wait ignore a branch pulse; first accept goes to 0x24.
    jr = 1'b1; jr_target = 32'h20; expect_fetch(32'h200, 32'd10); tick();
    jr = 1'b0; stall = 1'b1; tick();
    branch_taken = 1'b1; br_offset = 32'h100; tick();
    branch_taken = 1'b0; tick();
    stall = 1'b0; imem_rdy = 1'b0; branch_taken = 1'b1; tick();
    branch_taken = 1'b0; imem_rdy = 1'b1;
    chk("stall_pc", pc, 32'h20);
    chk("stall_cnt", fetch_cnt, 32'd11);
    expect_fetch(32'h20, 32'd11); tick();
    chk("post_stall_pc", pc, 32'h24);

    // Wrap from the top of the address space.
    jr = 1'b1; jr_target = 32'hFFFF_FFFC; expect_fetch(32'h24, 32'd12); tick();
    jr = 1'b0;
    chk("wrap_pcplus4", pcplus4, 32'h0);
    expect_fetch(32'hFFFF_FFFC, 32'd13); tick();
    chk("wrap_pc", pc, 32'h0);

    // Misaligned jr: error, halted, pc and count frozen; halt later ignored.
    jr = 1'b1; jr_target = 32'h202; jump = 1'b1; jump_index = 26'h100; tick();
    jr = 1'b0; jump = 1'b0;
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_pc", pc, 32'h0);
    chk("mis_cnt", fetch_cnt, 32'd14);
    halt = 1'b1; tick(); tick();
    halt = 1'b0;
    chk("halted_pc", pc, 32'h0);
    chk("halted_err", {31'd0, misalign_err}, 32'd1);

    // One-cycle reset clears the error and counter.
    reset = 1'b0; tick();
    reset = 1'b1;
    chk("rst2_pc", pc, RESET_PC);
    chk("rst2_err", {31'd0, misalign_err}, 32'd0);
    chk("rst2_cnt", fetch_cnt, 32'd0);
    tick();

    // halt wins over a would-be accept.
    halt = 1'b1; tick();
    halt = 1'b0;
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_pc", pc, RESET_PC);
    chk("halt_cnt", fetch_cnt, 32'd0);

    // Reset mid-fetch while memory is not ready.
    reset = 1'b0; tick();
    reset = 1'b1; tick();
    expect_fetch(32'h0, 32'd0); tick();
    expect_fetch(32'h4, 32'd1); tick();
    imem_rdy = 1'b0; reset = 1'b0; tick();
    reset = 1'b1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, RESET_PC);
    chk("midrst_cnt", fetch_cnt, 32'd0);
    tick();
    chk("midrst_fetch_req", {31'd0, imem_req}, 32'd1);
    tick(); tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_fetches actual=%0d outstanding required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sits directly downstream of the shift-left-by-2 stage.
- Takes that stage's word-aligned branch offset and jump index, and forms PC+4, the branch target, the jump target and the register-jump target.
- Updates PC once per accepted fetch and drives the instruction-memory request.
- Holds state across memory wait cycles, pipeline stalls and halt.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 32: width of the fetched-instruction counter.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: one clock; reset is synchronous and active-low; the system is in reset while reset==0 at a rising edge of clk.
- stall, input, 1: hazard hold; PC and the counter must not advance.
- imem_rdy, input, 1: instruction memory has returned the word at pc this cycle.
- halt, input, 1: stop fetching; sticky until reset.
- branch_taken, input, 1: conditional branch resolved taken.
- br_offset, input, 32: sign-extended immediate, already shifted left by 2.
- jump, input, 1: J/JAL.
- jump_index, input, 26: instruction index field.
- jr, input, 1: register jump.
- jr_target, input, 32: register value for jr.
- pc, output, 32: current fetch address.
- pcplus4, output, 32: pc + 4 (combinational, for link/branch).
- imem_req, output, 1: fetch request for pc.
- fetch_valid, output, 1: one-cycle pulse when a fetch is accepted (imem_rdy && !stall in FETCH).
- fetch_cnt, output, CNT_W: number of accepted fetches.
- misalign_err, output, 1: sticky; set by a jr to a non-word-aligned address.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, pc=RESET_PC, fetch_cnt=0, misalign_err=0.
  - imem_req=0, fetch_valid=0.
  - Reset aborts any outstanding fetch and has priority over every other input.
- States:
  - IDLE: one cycle after reset deasserts; imem_req=0; then go to FETCH unconditionally.
  - FETCH: imem_req=1.
    - Accept = imem_rdy && !stall && !halt.
    - On accept: pc <= next_pc; fetch_cnt += 1; fetch_valid=1 in the same cycle (combinational from state and inputs).
    - Without accept: pc held, fetch_valid=0.
  - HALTED: imem_req=0, pc held, fetch_valid=0. Exit only via reset.
- FETCH exits:
  - halt==1 -> HALTED. halt takes priority over accept, so no PC update that cycle.
  - jr && jr_target[1:0]!=2'b00 on an accept cycle -> misalign_err<=1, HALTED, pc unchanged, fetch_cnt unchanged.
- next_pc priority, highest first:
  - jr: jr_target.
  - jump: {pcplus4[31:28], jump_index, 2'b00}.
  - branch_taken: pcplus4 + br_offset.
  - otherwise: pcplus4.
- Arithmetic:
  - All 32-bit modulo 2^32; overflow wraps silently (pc=32'hFFFF_FFFC -> pcplus4=0).
  - br_offset is used as given; the block does no extra shift or sign extension.
  - fetch_cnt wraps at 2^CNT_W-1 -> 0.
- Redirect inputs (jr/jump/branch_taken) are sampled only on accept cycles. When asserted during stall or !imem_rdy they are ignored, so the upstream control must hold them until accepted.
- Simultaneous inputs:
  - stall && imem_rdy: no accept; the memory re-presents the word later.
  - halt && accept conditions true: halt wins.
  - jr with misaligned target && jump: jr wins and raises the error.
- pc is word aligned at all times; RESET_PC[1:0] must be 0 (checked by an assertion in the bench).

Decomposition:
- Shared package cpu_pkg holds:
  - state enum/localparams FS_IDLE=2'd0, FS_FETCH=2'd1, FS_HALTED=2'd2;
  - constant WORD_BYTES=4;
  - the next-pc select encodings.
- One natural sub-module: next_pc_mux. It is combinational, computes next_pc from pcplus4, br_offset, jump_index, jr_target and the select bits, and is reusable by a later pipelined fetch stage.
- Top level holds the FSM, the pc register and the counter.

Test Plan:
- Reset/sequential: reset low 2 cycles, release, imem_rdy=1 -> IDLE 1 cycle, then pc=0,4,8,C on successive cycles; fetch_cnt=3 after three accepts; fetch_valid high each cycle.
- Branch: pc=32'h40, branch_taken=1, br_offset=32'hFFFF_FFF0 -> next pc=32'h34; br_offset=32'h100 -> 32'h144.
- Jump/jr priority:
  - pc=32'h1000_0010, jump=1, jump_index=26'h00_0040 -> pc=32'h1000_0100.
  - Same cycle with jr=1, jr_target=32'h200 -> pc=32'h200.
- Stall/wait: pc=32'h20 with stall=1 for 3 cycles (or imem_rdy=0), branch_taken pulsed mid-stall -> pc stays 32'h20, fetch_cnt unchanged, then pc=32'h24 on the first accept.
- Error/halt:
  - jr=1, jr_target=32'h202 -> misalign_err=1, HALTED, imem_req=0, pc unchanged.
  - Later halt input ignored; reset low one cycle -> pc=RESET_PC, misalign_err=0.
- Wrap/reset mid-op: pc=32'hFFFF_FFFC, accept -> pc=0. Assert reset while imem_rdy=0 in FETCH -> next cycle IDLE, imem_req=0.
